// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: per-stage bundle widths, field offsets,
// bubble constants, stage-state encoding and saturating counter helpers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_t;

  // IF/ID: ctrl = {is_halted}, data = {pc, instr}
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  // ID/EX: ctrl = {is_halted, mem_write, mem_enable, wb_enable}, data = {rs1, rs2, imm, rd}
  localparam int IDEX_CTRL_W  = 4;
  localparam int IDEX_DATA_W  = 101;
  // EX/MEM: data = {alu_output, rs2, rd_id}
  localparam int EXMEM_CTRL_W = 4;
  localparam int EXMEM_DATA_W = 69;
  // MEM/WB: ctrl = {is_halted, wb_enable}, data = {wb_value, rd_id}
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 37;

  localparam int CTRL_WB_EN_BIT  = 0;
  localparam int CTRL_MEM_EN_BIT = 1;
  localparam int CTRL_MEM_WR_BIT = 2;
  localparam int CTRL_HALT_BIT   = 3;

  localparam int EXMEM_RD_LSB  = 0;
  localparam int EXMEM_RS2_LSB = 5;
  localparam int EXMEM_ALU_LSB = 37;

  localparam logic [IFID_CTRL_W-1:0]  IFID_BUBBLE  = '0;
  localparam logic [IDEX_CTRL_W-1:0]  IDEX_BUBBLE  = '0;
  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_BUBBLE = '0;
  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_BUBBLE = '0;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One enable-gated ctrl+data register; bubble load overrides a data load and
// rewrites only ctrl, leaving data as-is. Latency 1 cycle, no flow control.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int                 CTRL_W      = 4,
  parameter int                 DATA_W      = 69,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              bubble,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= BUBBLE_CTRL;
      data <= '0;
    end else if (bubble) begin
      ctrl <= BUBBLE_CTRL;
    end else if (load) begin
      ctrl <= in_ctrl;
      data <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with 2-entry skid buffer, flush and bubble injection.
// Latency 1 cycle; in_ready is registered and drops only once the skid entry is used.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/flush counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 CTRL_W      = 4,
  parameter int                 DATA_W      = 69,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       flush_count
`endif
);

  stage_state_t      state, next_state;
  logic              valid_q, ready_q;
  logic              accept, handoff;
  logic              main_load, main_bubble, main_sel_skid, skid_load;
  logic [CTRL_W-1:0] skid_ctrl, main_in_ctrl;
  logic [DATA_W-1:0] skid_data, main_in_data;

  // A flush squashes whatever upstream offers in the same cycle.
  assign accept    = in_valid & ready_q & ~flush;
  assign handoff   = valid_q & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state   <= next_state;
      valid_q <= (next_state != ST_EMPTY);
      ready_q <= (next_state != ST_SKID);
    end
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: if (accept) next_state = ST_FULL;
        ST_FULL: begin
          if (accept && !handoff)      next_state = ST_SKID;
          else if (!accept && handoff) next_state = ST_EMPTY;
        end
        ST_SKID:  if (handoff) next_state = ST_FULL;
        default:  next_state = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_load     = 1'b0;
    main_bubble   = flush;
    main_sel_skid = (state == ST_SKID);
    skid_load     = 1'b0;
    if (!flush) begin
      unique case (state)
        ST_EMPTY: main_load = accept;
        ST_FULL: begin
          main_load   = accept & handoff;
          skid_load   = accept & ~handoff;
          // Draining to empty must leave the bubble on out_ctrl.
          main_bubble = ~accept & handoff;
        end
        ST_SKID:  main_load = handoff;
        default:  main_load = 1'b0;
      endcase
    end
  end

  assign main_in_ctrl = main_sel_skid ? skid_ctrl : in_ctrl;
  assign main_in_data = main_sel_skid ? skid_data : in_data;

  pipe_skid_slot #(
    .CTRL_W      (CTRL_W),
    .DATA_W      (DATA_W),
    .BUBBLE_CTRL (BUBBLE_CTRL)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .bubble  (main_bubble),
    .in_ctrl (main_in_ctrl),
    .in_data (main_in_data),
    .ctrl    (out_ctrl),
    .data    (out_data)
  );

  pipe_skid_slot #(
    .CTRL_W      (CTRL_W),
    .DATA_W      (DATA_W),
    .BUBBLE_CTRL (BUBBLE_CTRL)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_load),
    .bubble  (flush),
    .in_ctrl (in_ctrl),
    .in_data (in_data),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (valid_q && !out_ready) stall_cycles <= sat_inc32(stall_cycles);
      if (flush && valid_q)      flush_count  <= sat_inc16(flush_count);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic
// compared against a queue-based model of the stage contents.
module tb_pipe_stage_reg;

  localparam int CTRL_W = 4;
  localparam int DATA_W = 69;
  localparam logic [CTRL_W-1:0] BUBBLE = '0;

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]       stall_cycles;
  logic [15:0]       flush_count;
`endif

  int errors = 0;
  int checks = 0;

  ent_t        q[$];
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .CTRL_W      (CTRL_W),
    .DATA_W      (DATA_W),
    .BUBBLE_CTRL (BUBBLE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (q.size() != 0);
    check("out_valid", 128'(out_valid), 128'(ev));
    check("in_ready", 128'(in_ready), 128'(q.size() < 2));
    if (ev) begin
      check("out_ctrl", 128'(out_ctrl), 128'(q[0].c));
      check("out_data", 128'(out_data), 128'(q[0].d));
    end else begin
      check("out_ctrl_bubble", 128'(out_ctrl), 128'(BUBBLE));
    end
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cycles", 128'(stall_cycles), 128'(m_stall));
    check("flush_count", 128'(flush_count), 128'(m_flush));
`endif
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model, check.
  task automatic cyc(input bit iv, input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                     input bit ordy, input bit fl);
    bit ov, ir;
    ent_t e;
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    ov = (q.size() != 0);
    ir = (q.size() < 2);
    if (ov && !ordy) m_stall++;
    if (fl && ov)    m_flush++;
    if (fl) begin
      q.delete();
    end else begin
      if (ov && ordy) void'(q.pop_front());
      if (iv && ir) begin
        e.c = ic;
        e.d = id;
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    q.delete();
    m_stall = 0;
    m_flush = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [95:0]       r;
    logic [DATA_W-1:0] d;

    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_ctrl", 128'(out_ctrl), 128'(BUBBLE));
    check("rst_out_data", 128'(out_data), 128'(0));
    reset = 1'b0;
    @(negedge clk);

    // Single transfer
    cyc(1, 4'b1011, 69'h1234, 1, 0);
    check("first_valid", 128'(out_valid), 128'(1));
    check("first_ctrl", 128'(out_ctrl), 128'(4'b1011));
    check("first_data", 128'(out_data), 128'(69'h1234));
    check("first_ready", 128'(in_ready), 128'(1));

    // Back-to-back stream, no bubbles
    cyc(1, 4'h1, 69'hA, 1, 0);
    check("stream_a", 128'(out_ctrl), 128'(4'h1));
    cyc(1, 4'h2, 69'hB, 1, 0);
    check("stream_b", 128'(out_ctrl), 128'(4'h2));
    cyc(1, 4'h3, 69'hC, 1, 0);
    check("stream_c", 128'(out_ctrl), 128'(4'h3));
    cyc(0, 4'h0, 69'h0, 1, 0);

    // Stall fills skid, releases in order
    cyc(1, 4'h5, 69'h55, 0, 0);
    cyc(1, 4'h6, 69'h66, 0, 0);
    check("skid_ready_low", 128'(in_ready), 128'(0));
    check("skid_hold_a", 128'(out_ctrl), 128'(4'h5));
    cyc(1, 4'h7, 69'h77, 0, 0);
    check("skid_still_a", 128'(out_data), 128'(69'h55));
    cyc(1, 4'h7, 69'h77, 1, 0);
    check("release_b", 128'(out_ctrl), 128'(4'h6));
    cyc(1, 4'h7, 69'h77, 1, 0);
    check("release_c", 128'(out_ctrl), 128'(4'h7));
    cyc(0, 4'h0, 69'h0, 1, 0);
    check("drained", 128'(out_valid), 128'(0));

    // Flush while in SKID with a live input
    cyc(1, 4'h9, 69'h99, 0, 0);
    cyc(1, 4'hA, 69'hAA, 0, 0);
    cyc(1, 4'hD, 69'hDD, 0, 1);
    check("flush_valid", 128'(out_valid), 128'(0));
    check("flush_ctrl", 128'(out_ctrl), 128'(BUBBLE));
    check("flush_ready", 128'(in_ready), 128'(1));
    cyc(0, 4'h0, 69'h0, 1, 0);
    check("flush_dropped", 128'(out_valid), 128'(0));
    cyc(1, 4'hE, 69'hEE, 1, 0);
    check("after_flush", 128'(out_ctrl), 128'(4'hE));

    // Asynchronous reset mid-cycle while FULL
    idle_inputs();
    out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 128'(out_valid), 128'(0));
    check("arst_ctrl", 128'(out_ctrl), 128'(BUBBLE));
    check("arst_data", 128'(out_data), 128'(0));
    check("arst_ready", 128'(in_ready), 128'(1));
    q.delete();
    m_stall = 0;
    m_flush = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs();

`ifdef PIPE_STAGE_PERF_EN
    do_reset();
    cyc(1, 4'h3, 69'h33, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 4'h0, 69'h0, 0, 0);
    check("perf_stall5", 128'(stall_cycles), 128'(5));
    cyc(0, 4'h0, 69'h0, 1, 1);
    check("perf_stall_final", 128'(stall_cycles), 128'(5));
    check("perf_flush1", 128'(flush_count), 128'(1));
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = {$urandom, $urandom, $urandom};
      d = r[DATA_W-1:0];
      cyc($urandom_range(0, 3) != 0, CTRL_W'($urandom_range(0, 15)), d,
          $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
